// File: rtl/ddr3_ca_delay_ctrl.sv
// DDR3 address/command lane delay-line controller.
// Turns a single step/reload command into spaced MOVE/LOAD pulses for one
// IOD lane, watches the lane's OUT_OF_RANGE flag and tracks the tap position.
module ddr3_ca_delay_ctrl #(
  parameter int STEP_W     = 7,
  parameter int MAX_TAP    = 127,
  parameter int INIT_TAP   = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic              FAB_CLK,
  input  logic              TX_SYNC_RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [STEP_W-1:0] CMD_STEPS,
  output logic              DELAY_LINE_MOVE_0,
  output logic              DELAY_LINE_DIRECTION_0,
  output logic              DELAY_LINE_LOAD_0,
  input  logic              DELAY_LINE_OUT_OF_RANGE_0,
  output logic [7:0]        TAP_COUNT,
  output logic [STEP_W-1:0] STEPS_DONE,
  output logic              DONE,
  output logic              ERR_RANGE
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [7:0]        TAP_MAX     = 8'(MAX_TAP);
  localparam logic [7:0]        TAP_INIT    = 8'(INIT_TAP);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIR_SETUP,
    S_MOVE,
    S_SETTLE,
    S_LOAD,
    S_LSETTLE,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              move_q, move_d;
  logic              dir_q, dir_d;
  logic              load_q, load_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        tap_q, tap_d;
  logic [STEP_W-1:0] sdone_q, sdone_d;
  logic [STEP_W-1:0] left_q, left_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enter_move;

  assign CMD_READY              = ready_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;
  assign DELAY_LINE_LOAD_0      = load_q;
  assign TAP_COUNT              = tap_q;
  assign STEPS_DONE             = sdone_q;
  assign DONE                   = done_q;
  assign ERR_RANGE              = err_q;

  // State and all output registers; reset aborts any sequence in flight.
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      move_q  <= 1'b0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tap_q   <= TAP_INIT;
      sdone_q <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      move_q  <= move_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tap_q   <= tap_d;
      sdone_q <= sdone_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output decode. Outputs are computed from the state
  // being entered so each registered output lines up with its state cycle;
  // the range-limit decision is therefore made on entry to MOVE.
  always_comb begin
    state_d    = state_q;
    move_d     = 1'b0;
    load_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_q;
    tap_d      = tap_q;
    sdone_d    = sdone_q;
    left_d     = left_q;
    cnt_d      = cnt_q;
    enter_move = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CMD_VALID && ready_q) begin
          err_d   = 1'b0;
          sdone_d = '0;
          left_d  = CMD_STEPS;
          case (CMD_OP)
            2'b01, 2'b10: begin
              if (CMD_STEPS != '0) begin
                state_d = S_DIR_SETUP;
                dir_d   = (CMD_OP == 2'b01);
              end else begin
                state_d = S_FIN;
              end
            end
            2'b11: begin
              state_d = S_LOAD;
              load_d  = 1'b1;
            end
            default: state_d = S_FIN;
          endcase
        end
      end

      S_DIR_SETUP: enter_move = 1'b1;

      S_MOVE: begin
        if (move_q) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LAST;
        end else begin
          state_d = S_FIN;
        end
      end

      S_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (DELAY_LINE_OUT_OF_RANGE_0) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tap_d   = dir_q ? (tap_q + 8'd1) : (tap_q - 8'd1);
          sdone_d = sdone_q + STEP_ONE;
          left_d  = left_q - STEP_ONE;
          if (left_q != STEP_ONE) begin
            enter_move = 1'b1;
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_LOAD: begin
        state_d = S_LSETTLE;
        cnt_d   = SETTLE_LAST;
        tap_d   = TAP_INIT;
      end

      S_LSETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_FIN;
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // A step at the range limit still spends its MOVE cycle, without a pulse.
    if (enter_move) begin
      state_d = S_MOVE;
      if (dir_q ? (tap_d == TAP_MAX) : (tap_d == '0)) begin
        err_d = 1'b1;
      end else begin
        move_d = 1'b1;
      end
    end

    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_FIN);
  end

endmodule
